// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: shared front-end types for the I-cache fill sequencer.
// Holds the fill FSM state encoding and the tag-memory packet opcode.
package bp_fe_pkg;

  typedef enum logic [3:0] {
    e_reset,
    e_clear,
    e_ready,
    e_wait_meta,
    e_send_cmd,
    e_wait_resp,
    e_write_data,
    e_write_tag,
    e_done
  } bp_fe_icache_fill_state_e;

  typedef enum logic {
    e_tag_clear = 1'b0,
    e_tag_set   = 1'b1
  } bp_fe_icache_tag_op_e;

endpackage

// File: rtl/bp_fe_icache_fill_ctrl.sv
// bp_fe_icache_fill_ctrl: I-cache miss-fill sequencer.
// Accepts one miss plus victim way, reads the block from memory, writes data
// then tag into the cache, and pulses completion.
// Define BP_FE_ICACHE_FILL_INIT_EN to run a tag-invalidate sweep of every set
// after each reset; without it the sweep state and counter are not built.
//
// state        | meaning
// e_reset      | held in / just out of reset, every output idle
// e_clear      | tag-invalidate sweep, one set per accepted tag packet
// e_ready      | idle, accepting a miss request
// e_wait_meta  | request address latched, waiting for the victim way
// e_send_cmd   | issuing the block-aligned read to memory
// e_wait_resp  | waiting for the block; consumed the cycle it arrives
// e_write_data | writing the returned block into the data memory
// e_write_tag  | writing the tag and marking the way valid
// e_done       | single-cycle completion pulse
module bp_fe_icache_fill_ctrl
  import bp_fe_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int ptag_width_p  = 28,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  localparam int block_offset_width_lp = $clog2(block_width_p/8),
  localparam int index_width_lp        = $clog2(sets_p),
  localparam int way_width_lp          = $clog2(assoc_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [paddr_width_p-1:0]  cache_req_addr_i,
  input  logic                      cache_req_v_i,
  output logic                      cache_req_ready_o,
  input  logic [way_width_lp-1:0]   cache_req_metadata_way_i,
  input  logic                      cache_req_metadata_v_i,
  output logic                      cache_req_complete_o,

  output logic [paddr_width_p-1:0]  mem_cmd_addr_o,
  output logic                      mem_cmd_v_o,
  input  logic                      mem_cmd_ready_i,
  input  logic [block_width_p-1:0]  mem_resp_data_i,
  input  logic                      mem_resp_v_i,
  output logic                      mem_resp_yumi_o,

  output logic [index_width_lp-1:0] data_mem_pkt_index_o,
  output logic [way_width_lp-1:0]   data_mem_pkt_way_o,
  output logic [block_width_p-1:0]  data_mem_pkt_data_o,
  output logic                      data_mem_pkt_v_o,
  input  logic                      data_mem_pkt_ready_i,

  output logic [index_width_lp-1:0] tag_mem_pkt_index_o,
  output logic [way_width_lp-1:0]   tag_mem_pkt_way_o,
  output logic [ptag_width_p-1:0]   tag_mem_pkt_tag_o,
  output logic                      tag_mem_pkt_opcode_o,
  output logic                      tag_mem_pkt_v_o,
  input  logic                      tag_mem_pkt_ready_i
);

  // Only the block address is kept; the byte offset is always zero on the memory side.
  localparam int blk_addr_width_lp = paddr_width_p - block_offset_width_lp;

  bp_fe_icache_fill_state_e state_q, state_d;

  logic [blk_addr_width_lp-1:0] addr_q;
  logic [way_width_lp-1:0]      way_q;
  logic [block_width_p-1:0]     data_q;

  logic ready_q, complete_q, cmd_v_q, data_v_q, tag_v_q;

  logic [index_width_lp-1:0] fill_index;
  logic                      unused_addr_lo;

  assign unused_addr_lo = ^cache_req_addr_i[block_offset_width_lp-1:0];
  assign fill_index     = addr_q[0 +: index_width_lp];

`ifdef BP_FE_ICACHE_FILL_INIT_EN
  localparam logic [index_width_lp-1:0] last_index_lp = index_width_lp'(sets_p - 1);

  logic [index_width_lp-1:0] sweep_q;

  // Sweep index advances on every accepted clear packet; wraps back to 0 after the last set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sweep_q <= '0;
    end else if ((state_q == e_clear) && tag_mem_pkt_ready_i) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end
`endif

  // Next-state decode for the fill sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_reset: begin
`ifdef BP_FE_ICACHE_FILL_INIT_EN
        state_d = e_clear;
`else
        state_d = e_ready;
`endif
      end
`ifdef BP_FE_ICACHE_FILL_INIT_EN
      e_clear:      if (tag_mem_pkt_ready_i && (sweep_q == last_index_lp)) state_d = e_ready;
`endif
      e_ready:      if (cache_req_v_i) state_d = cache_req_metadata_v_i ? e_send_cmd : e_wait_meta;
      e_wait_meta:  if (cache_req_metadata_v_i) state_d = e_send_cmd;
      e_send_cmd:   if (mem_cmd_ready_i) state_d = e_wait_resp;
      e_wait_resp:  if (mem_resp_v_i) state_d = e_write_data;
      e_write_data: if (data_mem_pkt_ready_i) state_d = e_write_tag;
      e_write_tag:  if (tag_mem_pkt_ready_i) state_d = e_done;
      e_done:       state_d = e_ready;
      default:      state_d = e_reset;
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_reset;
      ready_q    <= 1'b0;
      complete_q <= 1'b0;
      cmd_v_q    <= 1'b0;
      data_v_q   <= 1'b0;
      tag_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == e_ready);
      complete_q <= (state_d == e_done);
      cmd_v_q    <= (state_d == e_send_cmd);
      data_v_q   <= (state_d == e_write_data);
      tag_v_q    <= (state_d == e_write_tag) || (state_d == e_clear);
    end
  end

  // Capture the miss address, victim way and returned block as each arrives.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= '0;
      way_q  <= '0;
      data_q <= '0;
    end else begin
      if ((state_q == e_ready) && cache_req_v_i) begin
        addr_q <= cache_req_addr_i[paddr_width_p-1:block_offset_width_lp];
        if (cache_req_metadata_v_i) way_q <= cache_req_metadata_way_i;
      end
      if ((state_q == e_wait_meta) && cache_req_metadata_v_i) begin
        way_q <= cache_req_metadata_way_i;
      end
      if (mem_resp_yumi_o) begin
        data_q <= mem_resp_data_i;
      end
    end
  end

  assign cache_req_ready_o    = ready_q;
  assign cache_req_complete_o = complete_q;

  assign mem_cmd_addr_o  = {addr_q, {block_offset_width_lp{1'b0}}};
  assign mem_cmd_v_o     = cmd_v_q;
  assign mem_resp_yumi_o = (state_q == e_wait_resp) && mem_resp_v_i;

  assign data_mem_pkt_index_o = fill_index;
  assign data_mem_pkt_way_o   = way_q;
  assign data_mem_pkt_data_o  = data_q;
  assign data_mem_pkt_v_o     = data_v_q;

  assign tag_mem_pkt_way_o = way_q;
  assign tag_mem_pkt_tag_o = addr_q[blk_addr_width_lp-1 -: ptag_width_p];
  assign tag_mem_pkt_v_o   = tag_v_q;

`ifdef BP_FE_ICACHE_FILL_INIT_EN
  assign tag_mem_pkt_index_o  = (state_q == e_clear) ? sweep_q : fill_index;
  assign tag_mem_pkt_opcode_o = (state_q == e_clear) ? e_tag_clear : e_tag_set;
`else
  assign tag_mem_pkt_index_o  = fill_index;
  assign tag_mem_pkt_opcode_o = e_tag_set;
`endif

endmodule
